// File: rtl/cs_mem_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cs_mem_sequencer_if
//  Description : Bundle of the MIR request, main-memory handshake and status
//                signals used by the memory-access sequencer of the
//                microprogrammed control unit.
//                  master modport : the sequencer itself
//                    in  : RD/WR fields, datapath address, memory ACK,
//                          fault clear from the control store
//                    out : memory strobes and address, stall, done pulse,
//                          sticky fault and code, wait count
//                  slave modport  : the surrounding control unit / memory
//  Revision    : 1.0  initial release
// ============================================================================
interface cs_mem_sequencer_if #(
  parameter int DATAWIDTH_ADDR = 32,
  parameter int TIMEOUT_WIDTH  = 8
);

  logic                      CS_MEM_SEQ_RD_In;
  logic                      CS_MEM_SEQ_WR_In;
  logic [DATAWIDTH_ADDR-1:0] CS_MEM_SEQ_ADDR_InBUS;
  logic                      CS_MEM_SEQ_ACK_In;
  logic                      CS_MEM_SEQ_Fault_Clear_In;
  logic                      CS_MEM_SEQ_MemRD_Out;
  logic                      CS_MEM_SEQ_MemWR_Out;
  logic [DATAWIDTH_ADDR-1:0] CS_MEM_SEQ_MemADDR_OutBUS;
  logic                      CS_MEM_SEQ_Stall_Out;
  logic                      CS_MEM_SEQ_Done_Out;
  logic                      CS_MEM_SEQ_Fault_Out;
  logic [1:0]                CS_MEM_SEQ_FaultCode_OutBUS;
  logic [TIMEOUT_WIDTH-1:0]  CS_MEM_SEQ_WaitCount_OutBUS;

  modport master (
    input  CS_MEM_SEQ_RD_In,
    input  CS_MEM_SEQ_WR_In,
    input  CS_MEM_SEQ_ADDR_InBUS,
    input  CS_MEM_SEQ_ACK_In,
    input  CS_MEM_SEQ_Fault_Clear_In,
    output CS_MEM_SEQ_MemRD_Out,
    output CS_MEM_SEQ_MemWR_Out,
    output CS_MEM_SEQ_MemADDR_OutBUS,
    output CS_MEM_SEQ_Stall_Out,
    output CS_MEM_SEQ_Done_Out,
    output CS_MEM_SEQ_Fault_Out,
    output CS_MEM_SEQ_FaultCode_OutBUS,
    output CS_MEM_SEQ_WaitCount_OutBUS
  );

  modport slave (
    output CS_MEM_SEQ_RD_In,
    output CS_MEM_SEQ_WR_In,
    output CS_MEM_SEQ_ADDR_InBUS,
    output CS_MEM_SEQ_ACK_In,
    output CS_MEM_SEQ_Fault_Clear_In,
    input  CS_MEM_SEQ_MemRD_Out,
    input  CS_MEM_SEQ_MemWR_Out,
    input  CS_MEM_SEQ_MemADDR_OutBUS,
    input  CS_MEM_SEQ_Stall_Out,
    input  CS_MEM_SEQ_Done_Out,
    input  CS_MEM_SEQ_Fault_Out,
    input  CS_MEM_SEQ_FaultCode_OutBUS,
    input  CS_MEM_SEQ_WaitCount_OutBUS
  );

endinterface
`default_nettype wire

// File: rtl/cs_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cs_mem_sequencer
//  Description : Sequences main-memory reads/writes requested by the MIR
//                RD/WR fields. Latches the address, drives the strobe until
//                ACK, stalls the CSAI/MIR path meanwhile, and raises a sticky
//                fault on misaligned (01), timed-out (10) or RD&WR (11)
//                requests until the control store clears it.
//  Ports       : CS_MEM_SEQ_CLOCK_50     - clock, rising edge
//                CS_MEM_SEQ_RESET_InLow  - asynchronous active-low reset
//                bus (master modport)    - request, memory handshake, status
//  Note        : DATAWIDTH_ADDR / TIMEOUT_WIDTH must match the values the
//                connected interface instance was built with.
//                TIMEOUT_CYCLES legal range is 1 .. 2**TIMEOUT_WIDTH-1.
//  Revision    : 1.0  initial release
// ============================================================================
module cs_mem_sequencer #(
  parameter int DATAWIDTH_ADDR = 32,
  parameter int TIMEOUT_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  wire                  CS_MEM_SEQ_CLOCK_50,
  input  wire                  CS_MEM_SEQ_RESET_InLow,
  cs_mem_sequencer_if.master   bus
);

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_MISALIGN = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CODE_ILLEGAL  = 2'b11;

  // One extra bit so counter+1 can never wrap before the compare.
  localparam logic [TIMEOUT_WIDTH:0] TIMEOUT_LIMIT = (TIMEOUT_WIDTH+1)'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t                    state, state_nxt;
  logic [DATAWIDTH_ADDR-1:0] mem_addr, mem_addr_nxt;
  logic                      dir_wr, dir_wr_nxt;
  logic [TIMEOUT_WIDTH-1:0]  cnt, cnt_nxt;
  logic [TIMEOUT_WIDTH-1:0]  wait_count, wait_count_nxt;
  logic [1:0]                fault_code, fault_code_nxt;
  logic [TIMEOUT_WIDTH:0]    cnt_inc;
  logic                      req;

  assign req     = bus.CS_MEM_SEQ_RD_In | bus.CS_MEM_SEQ_WR_In;
  assign cnt_inc = {1'b0, cnt} + (TIMEOUT_WIDTH+1)'(1);

  // State and datapath registers
  always_ff @(posedge CS_MEM_SEQ_CLOCK_50 or negedge CS_MEM_SEQ_RESET_InLow) begin
    if (!CS_MEM_SEQ_RESET_InLow) begin
      state      <= S_IDLE;
      mem_addr   <= '0;
      dir_wr     <= 1'b0;
      cnt        <= '0;
      wait_count <= '0;
      fault_code <= CODE_NONE;
    end else begin
      state      <= state_nxt;
      mem_addr   <= mem_addr_nxt;
      dir_wr     <= dir_wr_nxt;
      cnt        <= cnt_nxt;
      wait_count <= wait_count_nxt;
      fault_code <= fault_code_nxt;
    end
  end

  // Next-state, datapath update and outputs
  always_comb begin
    state_nxt      = state;
    mem_addr_nxt   = mem_addr;
    dir_wr_nxt     = dir_wr;
    cnt_nxt        = cnt;
    wait_count_nxt = wait_count;
    fault_code_nxt = fault_code;

    bus.CS_MEM_SEQ_MemRD_Out = 1'b0;
    bus.CS_MEM_SEQ_MemWR_Out = 1'b0;
    bus.CS_MEM_SEQ_Stall_Out = 1'b0;
    bus.CS_MEM_SEQ_Done_Out  = 1'b0;
    bus.CS_MEM_SEQ_Fault_Out = 1'b0;

    case (state)
      S_IDLE: begin
        // Combinational stall so the MIR holds on the very edge the request
        // is accepted; gated by reset so every output reads 0 in reset.
        bus.CS_MEM_SEQ_Stall_Out = req & CS_MEM_SEQ_RESET_InLow;
        if (bus.CS_MEM_SEQ_RD_In && bus.CS_MEM_SEQ_WR_In) begin
          state_nxt      = S_FAULT;
          fault_code_nxt = CODE_ILLEGAL;
        end else if (req && (bus.CS_MEM_SEQ_ADDR_InBUS[1:0] != 2'b00)) begin
          state_nxt      = S_FAULT;
          fault_code_nxt = CODE_MISALIGN;
        end else if (req) begin
          state_nxt    = S_ACCESS;
          mem_addr_nxt = bus.CS_MEM_SEQ_ADDR_InBUS;
          dir_wr_nxt   = bus.CS_MEM_SEQ_WR_In;
          cnt_nxt      = '0;
        end
      end

      S_ACCESS: begin
        bus.CS_MEM_SEQ_MemRD_Out = ~dir_wr;
        bus.CS_MEM_SEQ_MemWR_Out = dir_wr;
        bus.CS_MEM_SEQ_Stall_Out = 1'b1;
        if (cnt != '1) begin
          cnt_nxt = cnt_inc[TIMEOUT_WIDTH-1:0];
        end
        // ACK is tested first so it wins over a coincident timeout.
        if (bus.CS_MEM_SEQ_ACK_In) begin
          state_nxt      = S_DONE;
          wait_count_nxt = cnt_inc[TIMEOUT_WIDTH-1:0];
        end else if (cnt_inc == TIMEOUT_LIMIT) begin
          state_nxt      = S_FAULT;
          fault_code_nxt = CODE_TIMEOUT;
        end
      end

      S_DONE: begin
        bus.CS_MEM_SEQ_Done_Out = 1'b1;
        state_nxt               = S_IDLE;
      end

      S_FAULT: begin
        bus.CS_MEM_SEQ_Stall_Out = 1'b1;
        bus.CS_MEM_SEQ_Fault_Out = 1'b1;
        if (bus.CS_MEM_SEQ_Fault_Clear_In) begin
          state_nxt      = S_IDLE;
          fault_code_nxt = CODE_NONE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.CS_MEM_SEQ_MemADDR_OutBUS   = mem_addr;
  assign bus.CS_MEM_SEQ_FaultCode_OutBUS = fault_code;
  assign bus.CS_MEM_SEQ_WaitCount_OutBUS = wait_count;

endmodule
`default_nettype wire

// File: tb/tb_cs_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cs_mem_sequencer
//  Description : Directed self-checking bench for cs_mem_sequencer built with
//                TIMEOUT_CYCLES = 4. Inputs change 1 ns after the rising
//                edge, outputs are sampled 2 ns after it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cs_mem_sequencer;

  localparam int AW = 32;
  localparam int TW = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cs_mem_sequencer_if #(.DATAWIDTH_ADDR(AW), .TIMEOUT_WIDTH(TW)) bus ();

  cs_mem_sequencer #(
    .DATAWIDTH_ADDR (AW),
    .TIMEOUT_WIDTH  (TW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .CS_MEM_SEQ_CLOCK_50    (clk),
    .CS_MEM_SEQ_RESET_InLow (rst_n),
    .bus                    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit views of the outputs for the checking task
  logic [31:0] o_rd, o_wr, o_addr, o_stall, o_done, o_fault, o_code, o_wait;
  assign o_rd    = 32'(bus.CS_MEM_SEQ_MemRD_Out);
  assign o_wr    = 32'(bus.CS_MEM_SEQ_MemWR_Out);
  assign o_addr  = bus.CS_MEM_SEQ_MemADDR_OutBUS;
  assign o_stall = 32'(bus.CS_MEM_SEQ_Stall_Out);
  assign o_done  = 32'(bus.CS_MEM_SEQ_Done_Out);
  assign o_fault = 32'(bus.CS_MEM_SEQ_Fault_Out);
  assign o_code  = 32'(bus.CS_MEM_SEQ_FaultCode_OutBUS);
  assign o_wait  = 32'(bus.CS_MEM_SEQ_WaitCount_OutBUS);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge (input drive point).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational paths settle, then sample.
  task automatic settle();
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"},    o_rd,    0);
    check({tag, "_wr"},    o_wr,    0);
    check({tag, "_stall"}, o_stall, 0);
    check({tag, "_done"},  o_done,  0);
    check({tag, "_fault"}, o_fault, 0);
    check({tag, "_code"},  o_code,  0);
    check({tag, "_addr"},  o_addr,  0);
    check({tag, "_wait"},  o_wait,  0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.CS_MEM_SEQ_RD_In          = 1'b0;
    bus.CS_MEM_SEQ_WR_In          = 1'b0;
    bus.CS_MEM_SEQ_ADDR_InBUS     = '0;
    bus.CS_MEM_SEQ_ACK_In         = 1'b0;
    bus.CS_MEM_SEQ_Fault_Clear_In = 1'b0;

    // ---------------- reset state ----------------
    next_cycle();
    next_cycle();
    settle();
    check_all_zero("reset");
    rst_n = 1'b1;
    next_cycle();

    // ---------------- read, ACK on 3rd strobe cycle ----------------
    bus.CS_MEM_SEQ_RD_In      = 1'b1;
    bus.CS_MEM_SEQ_ADDR_InBUS = 32'h0000_0104;
    settle();
    check("rd_req_stall", o_stall, 1);
    check("rd_req_nostrobe", o_rd, 0);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      if (i == 3) bus.CS_MEM_SEQ_ACK_In = 1'b1;
      settle();
      check($sformatf("rd_strobe%0d", i), o_rd, 1);
      check($sformatf("rd_stall%0d", i), o_stall, 1);
      check($sformatf("rd_nodone%0d", i), o_done, 0);
    end
    check("rd_addr", o_addr, 32'h104);
    next_cycle();
    bus.CS_MEM_SEQ_ACK_In = 1'b0;
    bus.CS_MEM_SEQ_RD_In  = 1'b0;
    settle();
    check("rd_done", o_done, 1);
    check("rd_done_stall", o_stall, 0);
    check("rd_done_strobe", o_rd, 0);
    check("rd_wait", o_wait, 3);
    next_cycle();
    settle();
    check("rd_done_pulse", o_done, 0);
    check("rd_idle_stall", o_stall, 0);

    // ---------------- write, immediate ACK ----------------
    bus.CS_MEM_SEQ_WR_In      = 1'b1;
    bus.CS_MEM_SEQ_ADDR_InBUS = 32'h0000_0008;
    next_cycle();
    bus.CS_MEM_SEQ_ACK_In = 1'b1;
    settle();
    check("wr_strobe", o_wr, 1);
    check("wr_no_rd", o_rd, 0);
    check("wr_addr", o_addr, 32'h8);
    next_cycle();
    bus.CS_MEM_SEQ_ACK_In = 1'b0;
    bus.CS_MEM_SEQ_WR_In  = 1'b0;
    settle();
    check("wr_done", o_done, 1);
    check("wr_strobe_off", o_wr, 0);
    check("wr_wait", o_wait, 1);
    check("wr_nofault", o_fault, 0);
    next_cycle();

    // ---------------- misaligned read ----------------
    bus.CS_MEM_SEQ_RD_In      = 1'b1;
    bus.CS_MEM_SEQ_ADDR_InBUS = 32'h0000_0102;
    next_cycle();
    settle();
    check("mis_fault", o_fault, 1);
    check("mis_code", o_code, 1);
    check("mis_nostrobe", o_rd, 0);
    check("mis_stall", o_stall, 1);
    check("mis_addr_hold", o_addr, 32'h8);
    next_cycle();
    settle();
    check("mis_sticky", o_fault, 1);
    bus.CS_MEM_SEQ_RD_In          = 1'b0;
    bus.CS_MEM_SEQ_Fault_Clear_In = 1'b1;
    next_cycle();
    bus.CS_MEM_SEQ_Fault_Clear_In = 1'b0;
    settle();
    check("mis_clr_fault", o_fault, 0);
    check("mis_clr_code", o_code, 0);
    check("mis_clr_stall", o_stall, 0);

    // ---------------- RD and WR both set ----------------
    bus.CS_MEM_SEQ_RD_In      = 1'b1;
    bus.CS_MEM_SEQ_WR_In      = 1'b1;
    bus.CS_MEM_SEQ_ADDR_InBUS = 32'h0000_0200;
    next_cycle();
    settle();
    check("ill_fault", o_fault, 1);
    check("ill_code", o_code, 3);
    check("ill_no_rd", o_rd, 0);
    check("ill_no_wr", o_wr, 0);
    bus.CS_MEM_SEQ_RD_In          = 1'b0;
    bus.CS_MEM_SEQ_WR_In          = 1'b0;
    bus.CS_MEM_SEQ_Fault_Clear_In = 1'b1;
    next_cycle();
    bus.CS_MEM_SEQ_Fault_Clear_In = 1'b0;
    settle();
    check("ill_clr", o_fault, 0);

    // ---------------- timeout: ACK never ----------------
    bus.CS_MEM_SEQ_RD_In      = 1'b1;
    bus.CS_MEM_SEQ_ADDR_InBUS = 32'h0000_0010;
    next_cycle();
    for (int i = 1; i <= 4; i++) begin
      settle();
      check($sformatf("to_strobe%0d", i), o_rd, 1);
      check($sformatf("to_nofault%0d", i), o_fault, 0);
      next_cycle();
    end
    settle();
    check("to_strobe_off", o_rd, 0);
    check("to_fault", o_fault, 1);
    check("to_code", o_code, 2);
    check("to_stall", o_stall, 1);
    check("to_wait_hold", o_wait, 1);
    bus.CS_MEM_SEQ_RD_In          = 1'b0;
    bus.CS_MEM_SEQ_Fault_Clear_In = 1'b1;
    next_cycle();
    bus.CS_MEM_SEQ_Fault_Clear_In = 1'b0;

    // ---------------- ACK on the timeout cycle wins ----------------
    bus.CS_MEM_SEQ_RD_In      = 1'b1;
    bus.CS_MEM_SEQ_ADDR_InBUS = 32'h0000_0020;
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      if (i == 4) bus.CS_MEM_SEQ_ACK_In = 1'b1;
      settle();
      check($sformatf("aw_strobe%0d", i), o_rd, 1);
    end
    next_cycle();
    bus.CS_MEM_SEQ_ACK_In = 1'b0;
    bus.CS_MEM_SEQ_RD_In  = 1'b0;
    settle();
    check("aw_done", o_done, 1);
    check("aw_nofault", o_fault, 0);
    check("aw_code", o_code, 0);
    check("aw_wait", o_wait, 4);
    next_cycle();

    // ---------------- reset during 2nd strobe cycle ----------------
    bus.CS_MEM_SEQ_RD_In      = 1'b1;
    bus.CS_MEM_SEQ_ADDR_InBUS = 32'h0000_0040;
    next_cycle();
    next_cycle();
    settle();
    check("rst_pre_strobe", o_rd, 1);
    check("rst_pre_addr", o_addr, 32'h40);
    rst_n = 1'b0;
    settle();
    check_all_zero("rst_mid");
    bus.CS_MEM_SEQ_RD_In = 1'b0;
    next_cycle();
    rst_n = 1'b1;

    // ---------------- spurious ACK in IDLE ----------------
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus.CS_MEM_SEQ_ACK_In = 1'b1;
      settle();
      check($sformatf("spur_nodone%0d", i), o_done, 0);
      check($sformatf("spur_nostall%0d", i), o_stall, 0);
      check($sformatf("spur_nostrobe%0d", i), o_rd, 0);
      next_cycle();
      bus.CS_MEM_SEQ_ACK_In = 1'b0;
      settle();
      check($sformatf("spur_after_done%0d", i), o_done, 0);
      check($sformatf("spur_after_wait%0d", i), o_wait, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cs_mem_sequencer.md
Name: cs_mem_sequencer

Overview:
- Sequences main-memory accesses requested by the microinstruction register (MIR RD/WR fields) for the microprogrammed control unit.
- Latches the address and drives the memory strobes.
- Stalls the CSAI/MIR path until memory ACK arrives.
- Detects misaligned, illegal and timed-out accesses and raises a sticky fault for the control store to service.

Parameters:
DATAWIDTH_ADDR, 32, width of address bus from datapath and to main memory
TIMEOUT_WIDTH, 8, width of wait-cycle counter
TIMEOUT_CYCLES, 200, max strobe cycles without ACK before fault (legal range 1..2^TIMEOUT_WIDTH-1)

Ports:
CS_MEM_SEQ_CLOCK_50  in  1  system clock, rising edge
CS_MEM_SEQ_RESET_InLow  in  1  asynchronous active-low reset
CS_MEM_SEQ_RD_In  in  1  MIR RD field (level, held while microinstruction stalled)
CS_MEM_SEQ_WR_In  in  1  MIR WR field
CS_MEM_SEQ_ADDR_InBUS  in  DATAWIDTH_ADDR  address from datapath
CS_MEM_SEQ_ACK_In  in  1  main-memory acknowledge
CS_MEM_SEQ_Fault_Clear_In  in  1  synchronous fault clear from control store
CS_MEM_SEQ_MemRD_Out  out  1  memory read strobe
CS_MEM_SEQ_MemWR_Out  out  1  memory write strobe
CS_MEM_SEQ_MemADDR_OutBUS  out  DATAWIDTH_ADDR  latched address to memory
CS_MEM_SEQ_Stall_Out  out  1  hold CSAI/MIR (no load while 1)
CS_MEM_SEQ_Done_Out  out  1  one-cycle pulse on completed access
CS_MEM_SEQ_Fault_Out  out  1  sticky fault flag
CS_MEM_SEQ_FaultCode_OutBUS  out  2  01 misaligned, 10 timeout, 11 RD&WR both set, 00 none
CS_MEM_SEQ_WaitCount_OutBUS  out  TIMEOUT_WIDTH  strobe cycles of last completed access

Behaviour:
- Reset (async, RESET_InLow=0):
  - State IDLE.
  - All strobes 0, Stall 0, Done 0, Fault 0, FaultCode 00, MemADDR 0, WaitCount 0, internal counter 0.
- States: IDLE, ACCESS, DONE, FAULT.
- IDLE:
  - Stall_Out = RD_In|WR_In, combinational, so the MIR does not advance at the request edge.
  - RD&WR both 1 -> FAULT, code 11.
  - Else (RD|WR) with ADDR[1:0]!=0 -> FAULT, code 01.
  - Else (RD|WR) -> ACCESS:
    - Latch ADDR into MemADDR.
    - Latch direction.
    - Counter cleared to 0.
  - ACK_In in IDLE is ignored.
- ACCESS:
  - MemRD or MemWR = 1 per latched direction; Stall 1.
  - Counter increments each cycle, saturating.
  - On ACK_In=1 -> DONE; WaitCount <= counter+1.
  - ACK=0 and counter+1==TIMEOUT_CYCLES -> FAULT, code 10.
  - ACK wins if it coincides with the timeout cycle.
  - RD/WR input changes during ACCESS are ignored.
- DONE:
  - Strobes 0, Stall 0, Done_Out 1 for exactly one cycle.
  - MIR loads next microinstruction at this edge.
  - -> IDLE unconditionally.
- FAULT:
  - Strobes 0, Stall 1, Fault 1, FaultCode held.
  - Fault_Clear_In=1 -> IDLE; Fault and FaultCode return to 0 on that edge.
  - A new request is evaluated only from the following cycle.
- Access latency: request seen in cycle 0, strobe asserted cycles 1..N, ACK in cycle N, Done in cycle N+1. Minimum request-to-Done is 2 cycles.
- Back-to-back accesses: the earliest next strobe is 2 cycles after DONE (DONE -> IDLE -> ACCESS).
- Reset asserted mid-ACCESS: strobes drop asynchronously; a pending ACK is lost (memory side must tolerate).
- MemADDR holds its value outside ACCESS. WaitCount updates only on successful completion.

Test Plan:
- Read with ACK on 3rd strobe cycle: RD=1, ADDR=0x0000_0104 -> MemRD high 3 cycles, MemADDR=0x104, Done pulse 1 cycle after ACK, WaitCount=3, Stall low only in DONE cycle.
- Write with immediate ACK: WR=1, ADDR=0x0000_0008, ACK high first strobe cycle -> MemWR 1 cycle, WaitCount=1, Done next cycle, no fault.
- Misaligned and illegal requests:
  - RD=1, ADDR=0x0000_0102 -> no strobe, FAULT code 01, Stall stays 1.
  - Fault_Clear pulse -> Fault 0, IDLE.
  - Repeat with RD=WR=1 -> code 11.
- Timeout with TIMEOUT_CYCLES=4, ACK never -> MemRD high exactly 4 cycles then FAULT code 10.
- Rerun with ACK on the 4th strobe cycle -> Done, no fault (ACK wins).
- Reset and spurious ACK:
  - Assert RESET_InLow=0 during 2nd strobe cycle -> all outputs 0 immediately.
  - After release, ACK pulses in IDLE cause no Done and no state change.
